// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift/rotate unit: mode codes,
// FSM state encoding and the amount/count register width.
package shift_pkg;

  typedef enum logic [2:0] {
    MODE_SHR  = 3'b000,
    MODE_SHRA = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_ROR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_PASS = 3'b101
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Count register must hold the value WIDTH itself, hence the extra bit.
  function automatic int amt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational move of amt positions (amt <= STEP) for every mode.
// hi only evolves for SHL, where it collects bits leaving the MSB.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = amt_width(WIDTH)
) (
  input  logic [2:0]       mode,
  input  logic [AW-1:0]    amt,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo_next,
  output logic [WIDTH-1:0] hi_next
);

  localparam logic [AW-1:0] W_A = AW'(WIDTH);

  logic [2*WIDTH-1:0] shl_cat;
  logic [AW-1:0]      back;

  always_comb begin
    shl_cat = {hi, lo} << amt;
    back    = W_A - amt;
    lo_next = lo;
    hi_next = hi;
    case (mode)
      MODE_SHR:  lo_next = lo >> amt;
      MODE_SHRA: lo_next = $signed(lo) >>> amt;
      MODE_SHL: begin
        lo_next = shl_cat[WIDTH-1:0];
        hi_next = shl_cat[2*WIDTH-1:WIDTH];
      end
      // a shift by WIDTH yields zero, so amt=0 rotates collapse to lo
      MODE_ROR:  lo_next = (lo >> amt) | (lo << back);
      MODE_ROL:  lo_next = (lo << amt) | (lo >> back);
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_rotate_unit.sv
// Iterative shifter/rotator: captures an operand, moves it up to STEP bits
// per cycle in SHIFT, then publishes the result with a one-cycle done.
module shift_rotate_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] zlow,
  output logic [WIDTH-1:0] zhigh
);

  localparam int AW = amt_width(WIDTH);
  localparam int LW = AW - 1;
  localparam logic [AW-1:0] W_A    = AW'(WIDTH);
  localparam logic [AW-1:0] STEP_A = AW'(STEP);

  state_e           state, state_next;
  logic [WIDTH-1:0] lo, hi, lo_next, hi_next;
  logic [AW-1:0]    cnt, amt, n_eff;
  logic [2:0]       mode_q;
  logic             capture;

  assign capture = start && (state != ST_SHIFT);
  assign amt     = (cnt > STEP_A) ? STEP_A : cnt;
  assign busy    = (state == ST_SHIFT);
  assign done    = (state == ST_DONE);

  always_comb begin
    n_eff = '0;
    case (mode)
      MODE_ROR, MODE_ROL:           n_eff = {1'b0, y[LW-1:0]};
      MODE_SHR, MODE_SHRA, MODE_SHL: n_eff = (y >= WIDTH'(WIDTH)) ? W_A : y[AW-1:0];
      default: ;
    endcase
  end

  shift_step #(.WIDTH(WIDTH), .AW(AW)) u_step (
    .mode    (mode_q),
    .amt     (amt),
    .lo      (lo),
    .hi      (hi),
    .lo_next (lo_next),
    .hi_next (hi_next)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (capture) state_next = ST_SHIFT;
      ST_SHIFT: if (cnt == '0) state_next = ST_DONE;
      ST_DONE:  state_next = capture ? ST_SHIFT : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      lo     <= '0;
      hi     <= '0;
      cnt    <= '0;
      mode_q <= '0;
      zlow   <= '0;
      zhigh  <= '0;
    end else if (capture) begin
      lo     <= x;
      hi     <= '0;
      cnt    <= n_eff;
      mode_q <= mode;
    end else if (state == ST_SHIFT) begin
      if (cnt != '0) begin
        lo  <= lo_next;
        hi  <= hi_next;
        cnt <= cnt - amt;
      end else begin
        zlow  <= lo;
        zhigh <= hi;
      end
    end
  end

endmodule
